// File: rtl/i2s_pkg.sv
// Shared widths and types for the I2S microphone receive path.
package i2s_pkg;
  localparam int I2S_DATA_W    = 18;
  localparam int I2S_SLOT_BITS = 24;

  typedef enum logic {CH_LEFT = 1'b0, CH_RIGHT = 1'b1} i2s_ch_t;
  typedef logic [17:0] i2s_sample_t;
endpackage

// File: rtl/sync_edge_det.sv
// Synchroniser for an oversampled bit clock plus its companion data line,
// producing registered one-cycle rise/fall strobes and the synced data level.
module sync_edge_det
  import i2s_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic edge_in,
  input  logic data_in,
  output logic data_level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] edge_sync_q, edge_sync_d;
  logic [STAGES-1:0] data_sync_q, data_sync_d;
  logic              edge_prev_q, edge_prev_d;
  logic              rise_q, rise_d;
  logic              fall_q, fall_d;
  logic              edge_lvl;

  // Both lines share the same depth so data stays aligned with the edges.
  assign edge_lvl = edge_sync_q[STAGES-1];

  always_comb begin
    edge_sync_d = {edge_sync_q[STAGES-2:0], edge_in};
    data_sync_d = {data_sync_q[STAGES-2:0], data_in};
    edge_prev_d = edge_lvl;
    rise_d      = edge_lvl & ~edge_prev_q;
    fall_d      = ~edge_lvl & edge_prev_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      edge_sync_q <= '0;
      data_sync_q <= '0;
      edge_prev_q <= 1'b0;
      rise_q      <= 1'b0;
      fall_q      <= 1'b0;
    end else begin
      edge_sync_q <= edge_sync_d;
      data_sync_q <= data_sync_d;
      edge_prev_q <= edge_prev_d;
      rise_q      <= rise_d;
      fall_q      <= fall_d;
    end
  end

  assign data_level = data_sync_q[STAGES-1];
  assign rise       = rise_q;
  assign fall       = fall_q;

endmodule

// File: rtl/i2s_mic_rx.sv
// I2S master receiver: drives word select, deserialises the mic data line and
// presents tagged samples on a one-deep valid/ready holding register.
module i2s_mic_rx
  import i2s_pkg::*;
#(
  parameter int DATA_W      = I2S_DATA_W,
  parameter int SLOT_BITS   = I2S_SLOT_BITS,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk_48mhz,
  input  logic              reset,
  input  logic              bclk,
  input  logic              sd_in,
  output logic              ws_out,
  output logic [DATA_W-1:0] sample_data,
  output logic              sample_left,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic              overrun
);

  localparam int                CNT_W    = $clog2(SLOT_BITS);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SLOT_BITS - 1);
  localparam logic [CNT_W-1:0] LSB_BIT  = CNT_W'(DATA_W);

  logic bclk_rise, bclk_fall, sd_lvl;

  sync_edge_det #(.STAGES(SYNC_STAGES)) u_bclk_sync (
    .clk        (clk_48mhz),
    .reset      (reset),
    .edge_in    (bclk),
    .data_in    (sd_in),
    .data_level (sd_lvl),
    .rise       (bclk_rise),
    .fall       (bclk_fall)
  );

  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              primed_q, primed_d;
  i2s_ch_t           ws_q, ws_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              left_q, left_d;
  logic              valid_q, valid_d;
  logic              overrun_q, overrun_d;
  logic [DATA_W-1:0] captured;
  logic              in_data_bits;
  logic              completion;

  // Stream contract: a beat transfers on any clk_48mhz edge where sample_valid
  // and sample_ready are both high; data/flags hold while valid && !ready,
  // except that a new completion overwrites the held sample and sets overrun.
  always_comb begin
    captured     = {shift_q[DATA_W-2:0], sd_lvl};
    in_data_bits = (bit_cnt_q != '0) && (bit_cnt_q <= LSB_BIT);
    completion   = bclk_rise && (bit_cnt_q == LSB_BIT) && primed_q;

    bit_cnt_d = bit_cnt_q;
    primed_d  = primed_q;
    ws_d      = ws_q;
    shift_d   = shift_q;
    data_d    = data_q;
    left_d    = left_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;

    // Word select moves on the falling edge; k=0 after it is the I2S delay bit.
    if (bclk_fall) begin
      if (bit_cnt_q == LAST_BIT) begin
        bit_cnt_d = '0;
        ws_d      = (ws_q == CH_LEFT) ? CH_RIGHT : CH_LEFT;
        primed_d  = 1'b1;
      end else begin
        bit_cnt_d = bit_cnt_q + 1'b1;
      end
    end

    if (bclk_rise && in_data_bits) begin
      shift_d = captured;
    end

    if (valid_q && sample_ready) begin
      valid_d = 1'b0;
    end

    if (completion) begin
      data_d  = captured;
      left_d  = (ws_q == CH_LEFT);
      valid_d = 1'b1;
      if (valid_q && !sample_ready) begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_48mhz) begin
    if (!reset) begin
      bit_cnt_q <= '0;
      primed_q  <= 1'b0;
      ws_q      <= CH_LEFT;
      shift_q   <= '0;
      data_q    <= '0;
      left_q    <= 1'b0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      primed_q  <= primed_d;
      ws_q      <= ws_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      left_q    <= left_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign ws_out       = ws_q;
  assign sample_data  = data_q;
  assign sample_left  = left_q;
  assign sample_valid = valid_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_i2s_mic_rx.sv
// Directed bench for i2s_mic_rx: free-running bclk generator with an I2S mic
// model that follows ws_out, plus one task per scenario.
module tb_i2s_mic_rx;
  import i2s_pkg::*;

  localparam int DATA_W      = I2S_DATA_W;
  localparam int SLOT_BITS   = I2S_SLOT_BITS;
  localparam int SYNC_STAGES = 2;
  localparam int LAT         = SYNC_STAGES + 2;
  localparam int SLOT_CYC    = SLOT_BITS * 21;

  logic              clk_48mhz = 1'b0;
  logic              reset = 1'b0;
  logic              bclk = 1'b0;
  logic              sd_in = 1'b0;
  logic              sample_ready = 1'b0;
  logic              ws_out;
  logic [DATA_W-1:0] sample_data;
  logic              sample_left;
  logic              sample_valid;
  logic              overrun;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int rise_cnt = 0;
  int fall_cnt = 0;
  int lsb_cnt  = 0;
  int lsb_cyc  = 0;
  int mic_pos  = 100;
  logic              mic_ws = 1'b0;
  logic [DATA_W-1:0] mic_l = '0;
  logic [DATA_W-1:0] mic_r = '0;
  logic [DATA_W-1:0] mic_word = '0;
  logic [DATA_W:0]   exp_q[$];

  i2s_mic_rx #(
    .DATA_W      (DATA_W),
    .SLOT_BITS   (SLOT_BITS),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clk_48mhz    (clk_48mhz),
    .reset        (reset),
    .bclk         (bclk),
    .sd_in        (sd_in),
    .ws_out       (ws_out),
    .sample_data  (sample_data),
    .sample_left  (sample_left),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .overrun      (overrun)
  );

  // clock/reset block
  always #10 clk_48mhz = ~clk_48mhz;
  always @(posedge clk_48mhz) cyc <= cyc + 1;

  initial begin
    repeat (60000) @(posedge clk_48mhz);
    $display("FAIL watchdog: got cycle %0d expected end before 60000", cyc);
    $fatal(1, "watchdog expired");
  end

  // bclk generator and mic model: the mic restarts its bit position on the
  // first rising edge that sees a new ws level, then sends MSB first.
  initial begin
    int j;
    forever begin
      repeat (10) @(negedge clk_48mhz);
      bclk = 1'b1;
      rise_cnt++;
      if (ws_out !== mic_ws) begin
        mic_ws   = ws_out;
        mic_pos  = 0;
        mic_word = ws_out ? mic_r : mic_l;
      end else begin
        mic_pos++;
      end
      if (mic_pos == DATA_W) begin
        lsb_cyc = cyc;
        lsb_cnt++;
      end
      repeat (11) @(negedge clk_48mhz);
      bclk = 1'b0;
      fall_cnt++;
      j = mic_pos + 1;
      if (j >= 1 && j <= DATA_W) sd_in = mic_word[DATA_W - j];
      else sd_in = 1'b0;
    end
  end

  // driver tasks
  task automatic wait_valid(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk_48mhz);
      if (sample_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_ws(input logic lvl, input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk_48mhz);
      if (ws_out === lvl) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_left_start(output bit ok);
    bit ok1;
    wait_ws(1'b1, 2 * SLOT_CYC, ok1);
    wait_ws(1'b0, 2 * SLOT_CYC, ok);
    ok = ok & ok1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    sample_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_48mhz);
      n_checks++;
      if ({ws_out, sample_valid, sample_left, overrun, sample_data} !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs cycle %0d: got ws=%b valid=%b left=%b ovr=%b data=%h expected all 0",
                 i, ws_out, sample_valid, sample_left, overrun, sample_data);
      end
    end
  endtask

  task automatic test_ws_period();
    int r0, rel, t1;
    bit ok;
    r0 = rise_cnt;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_48mhz);
      if (rise_cnt != r0) break;
    end
    reset = 1'b1;
    rel = fall_cnt;
    wait_ws(1'b1, 2 * SLOT_CYC, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL ws_first_toggle: got ws=%b expected 1 within %0d cycles", ws_out, 2 * SLOT_CYC);
    end
    n_checks++;
    if (fall_cnt - rel != SLOT_BITS) begin
      n_fail++;
      $display("FAIL ws_first_falls: got %0d falls expected %0d", fall_cnt - rel, SLOT_BITS);
    end
    n_checks++;
    if (sample_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL partial_slot_discard: got valid=%b expected 0", sample_valid);
    end
    sample_ready = 1'b1;
    t1 = fall_cnt;
    wait_ws(1'b0, 2 * SLOT_CYC, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL ws_second_toggle: got ws=%b expected 0", ws_out);
    end
    n_checks++;
    if (fall_cnt - t1 != SLOT_BITS) begin
      n_fail++;
      $display("FAIL ws_half_period: got %0d falls expected %0d", fall_cnt - t1, SLOT_BITS);
    end
    n_checks++;
    if (fall_cnt - rel != 2 * SLOT_BITS) begin
      n_fail++;
      $display("FAIL ws_frame: got %0d falls expected %0d", fall_cnt - rel, 2 * SLOT_BITS);
    end
  endtask

  task automatic test_stream();
    bit ok;
    logic [DATA_W:0] exp;
    sample_ready = 1'b1;
    wait_left_start(ok);
    mic_l = 18'h2A5A5;
    mic_r = 18'h15A5A;
    exp_q.push_back({1'b1, 18'h2A5A5});
    exp_q.push_back({1'b0, 18'h15A5A});
    for (int b = 0; b < 2; b++) begin
      wait_valid(2 * SLOT_CYC, ok);
      exp = exp_q.pop_front();
      n_checks++;
      if (!ok) begin
        n_fail++;
        $display("FAIL stream_timeout beat %0d: got valid=%b expected 1", b, sample_valid);
      end
      n_checks++;
      if ({sample_left, sample_data} !== exp) begin
        n_fail++;
        $display("FAIL stream_beat %0d: got left=%b data=%h expected left=%b data=%h",
                 b, sample_left, sample_data, exp[DATA_W], exp[DATA_W-1:0]);
      end
      n_checks++;
      if (cyc - lsb_cyc != LAT) begin
        n_fail++;
        $display("FAIL stream_latency beat %0d: got %0d cycles expected %0d", b, cyc - lsb_cyc, LAT);
      end
    end
  endtask

  task automatic test_ready_on_completion();
    bit ok;
    int l;
    sample_ready = 1'b1;
    wait_left_start(ok);
    mic_l = 18'h12345;
    mic_r = 18'h2ABCD;
    sample_ready = 1'b0;
    wait_valid(2 * SLOT_CYC, ok);
    n_checks++;
    if (!ok || {sample_left, sample_data} !== {1'b1, 18'h12345}) begin
      n_fail++;
      $display("FAIL roc_held: got valid=%b left=%b data=%h expected 1 1 12345",
               sample_valid, sample_left, sample_data);
    end
    l = lsb_cnt;
    for (int i = 0; i < 2 * SLOT_CYC; i++) begin
      if (lsb_cnt != l) break;
      @(negedge clk_48mhz);
    end
    while (cyc < lsb_cyc + LAT - 1) @(negedge clk_48mhz);
    n_checks++;
    if ({sample_valid, sample_data} !== {1'b1, 18'h12345}) begin
      n_fail++;
      $display("FAIL roc_before: got valid=%b data=%h expected 1 12345", sample_valid, sample_data);
    end
    sample_ready = 1'b1;
    @(negedge clk_48mhz);
    n_checks++;
    if ({sample_valid, sample_left, sample_data} !== {1'b1, 1'b0, 18'h2ABCD}) begin
      n_fail++;
      $display("FAIL roc_new_sample: got valid=%b left=%b data=%h expected 1 0 2abcd",
               sample_valid, sample_left, sample_data);
    end
    n_checks++;
    if (overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL roc_no_overrun: got %b expected 0", overrun);
    end
    @(negedge clk_48mhz);
    n_checks++;
    if (sample_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL roc_drain: got valid=%b expected 0", sample_valid);
    end
  endtask

  task automatic test_overrun();
    bit ok;
    sample_ready = 1'b1;
    wait_left_start(ok);
    mic_l = 18'h00001;
    mic_r = 18'h3FFFF;
    sample_ready = 1'b0;
    wait_valid(2 * SLOT_CYC, ok);
    n_checks++;
    if (!ok || {sample_left, sample_data, overrun} !== {1'b1, 18'h00001, 1'b0}) begin
      n_fail++;
      $display("FAIL ovr_first: got valid=%b left=%b data=%h ovr=%b expected 1 1 00001 0",
               sample_valid, sample_left, sample_data, overrun);
    end
    ok = 1'b0;
    for (int i = 0; i < 2 * SLOT_CYC; i++) begin
      @(negedge clk_48mhz);
      if (overrun === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL ovr_flag: got %b expected 1", overrun);
    end
    repeat (5) @(negedge clk_48mhz);
    n_checks++;
    if ({sample_valid, sample_left, sample_data} !== {1'b1, 1'b0, 18'h3FFFF}) begin
      n_fail++;
      $display("FAIL ovr_held: got valid=%b left=%b data=%h expected 1 0 3ffff",
               sample_valid, sample_left, sample_data);
    end
    sample_ready = 1'b1;
    @(negedge clk_48mhz);
    sample_ready = 1'b0;
    n_checks++;
    if (sample_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL ovr_accept: got valid=%b expected 0", sample_valid);
    end
    n_checks++;
    if (overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL ovr_sticky: got %b expected 1", overrun);
    end
  endtask

  task automatic test_reset_mid_slot();
    bit ok;
    sample_ready = 1'b1;
    wait_left_start(ok);
    mic_l = 18'h0F0F0;
    mic_r = 18'h30C3C;
    for (int i = 0; i < SLOT_CYC; i++) begin
      @(negedge clk_48mhz);
      if (mic_pos == 9) break;
    end
    reset = 1'b0;
    @(negedge clk_48mhz);
    n_checks++;
    if ({ws_out, sample_valid, sample_left, overrun, sample_data} !== '0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got ws=%b valid=%b left=%b ovr=%b data=%h expected all 0",
               ws_out, sample_valid, sample_left, overrun, sample_data);
    end
    reset = 1'b1;
    wait_valid(3 * SLOT_CYC, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL midreset_timeout: got valid=%b expected 1", sample_valid);
    end
    n_checks++;
    if (ws_out !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_partial: got ws=%b at first sample expected 1", ws_out);
    end
    n_checks++;
    if ({sample_left, sample_data} !== {1'b0, 18'h30C3C}) begin
      n_fail++;
      $display("FAIL midreset_sample: got left=%b data=%h expected 0 30c3c", sample_left, sample_data);
    end
    n_checks++;
    if (overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_overrun: got %b expected 0", overrun);
    end
  endtask

  initial begin
    test_reset();
    test_ws_period();
    test_stream();
    test_ready_on_completion();
    test_overrun();
    test_reset_mid_slot();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
